// File: rtl/flt2fix_unit.sv
// ---------------------------------------------------------------------------
// flt2fix_unit
//   Converts an IEEE half-precision operand into a signed 8.8 fixed-point
//   value using a small multi-cycle datapath. The significand is shifted by
//   one bit per cycle, so latency depends on the exponent: 2+k edges, where k
//   is the shift distance picked during classification.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   request pulse, accepted only in IDLE or DONE
//   fp_in    in  16   half-precision operand {sign, exp[4:0], man[9:0]}
//   fix_out  out 16   signed 8.8 result, updated only in FINISH
//   ovf      out  1   saturated or NaN operand, valid while done=1
//   busy     out  1   conversion in progress (CLASSIFY/SHIFT/FINISH)
//   done     out  1   result valid; held until the next accepted start
//
// Handshake: start is sampled on every rising edge but only takes effect
// while busy=0 (state IDLE or DONE). On acceptance fp_in is captured, done
// and ovf drop on that same edge, and busy rises. While busy=1 start is
// ignored. done rises on the edge that leaves FINISH and stays high until
// the next accepted start, so a start in DONE runs back to back.
// ---------------------------------------------------------------------------
module flt2fix_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fp_in,
  output logic [15:0] fix_out,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    FINISH   = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Operand class decided in CLASSIFY and used to pick the FINISH result.
  typedef enum logic [1:0] {
    CL_NUM  = 2'd0,
    CL_ZERO = 2'd1,
    CL_OVF  = 2'd2,
    CL_NAN  = 2'd3
  } class_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] op;        // latched operand
  logic [15:0] mag;       // working magnitude, 8.8 once shifting is done
  logic [4:0]  k;         // remaining shift count
  logic        dir_left;  // 1: shift left, 0: shift right
  class_t      cls;

  logic        accept;

  // Classification of the latched operand
  logic [4:0]  c_exp;
  logic [9:0]  c_man;
  logic [15:0] c_mag;
  logic [4:0]  c_k;
  logic        c_left;
  class_t      c_cls;

  // Result selected in FINISH
  logic [15:0] f_res;
  logic        f_ovf;
  logic        f_exact_neg128;

  // -------------------------------------------------------------------------
  // Handshake / status
  // -------------------------------------------------------------------------
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == CLASSIFY) || (state == SHIFT) || (state == FINISH);
  assign done   = (state == DONE);

  // -------------------------------------------------------------------------
  // Classification. mag holds 1.man scaled by 2^10; the 8.8 result is
  // mag * 2^(exp-17), hence the shift distance |exp-17|.
  // -------------------------------------------------------------------------
  always_comb begin
    c_exp  = op[14:10];
    c_man  = op[9:0];
    c_mag  = {5'b00000, 1'b1, c_man};
    c_k    = 5'd0;
    c_left = 1'b0;
    c_cls  = CL_NUM;
    if ((c_exp == 5'd31) && (c_man != 10'd0)) begin
      c_cls = CL_NAN;
    end else if (c_exp >= 5'd22) begin
      // Includes infinity; magnitude is at least 128.0.
      c_cls = CL_OVF;
    end else if (c_exp <= 5'd6) begin
      // Zero, subnormal, or a value below one LSB of the result.
      c_cls = CL_ZERO;
    end else if (c_exp <= 5'd16) begin
      c_k    = 5'd17 - c_exp;
      c_left = 1'b0;
    end else begin
      c_k    = c_exp - 5'd17;
      c_left = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Result selection for FINISH
  // -------------------------------------------------------------------------
  assign f_exact_neg128 = (op[14:10] == 5'd22) && (op[9:0] == 10'd0);

  always_comb begin
    f_res = 16'h0000;
    f_ovf = 1'b0;
    case (cls)
      CL_NUM: begin
        // Negating a zero magnitude gives zero, so no negative zero appears.
        if (op[15]) f_res = (~mag) + 16'd1;
        else        f_res = mag;
      end
      CL_ZERO: begin
        f_res = 16'h0000;
        f_ovf = 1'b0;
      end
      CL_OVF: begin
        if (op[15]) begin
          // -128.0 is representable exactly as 16'h8000.
          f_res = 16'h8000;
          f_ovf = !f_exact_neg128;
        end else begin
          f_res = 16'h7FFF;
          f_ovf = 1'b1;
        end
      end
      CL_NAN: begin
        f_res = 16'h0000;
        f_ovf = 1'b1;
      end
      default: begin
        f_res = 16'h0000;
        f_ovf = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = CLASSIFY;
      CLASSIFY: state_nxt = (c_k == 5'd0) ? FINISH : SHIFT;
      SHIFT:    if (k == 5'd1) state_nxt = FINISH;
      FINISH:   state_nxt = DONE;
      DONE:     if (accept) state_nxt = CLASSIFY;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op       <= 16'h0000;
      mag      <= 16'h0000;
      k        <= 5'd0;
      dir_left <= 1'b0;
      cls      <= CL_ZERO;
      fix_out  <= 16'h0000;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op  <= fp_in;
            ovf <= 1'b0;
          end
        end
        CLASSIFY: begin
          mag      <= c_mag;
          k        <= c_k;
          dir_left <= c_left;
          cls      <= c_cls;
        end
        SHIFT: begin
          // Right shifts drop the low bit: truncation toward zero.
          if (dir_left) mag <= {mag[14:0], 1'b0};
          else          mag <= {1'b0, mag[15:1]};
          k <= k - 5'd1;
        end
        FINISH: begin
          fix_out <= f_res;
          ovf     <= f_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2fix_unit.sv
// ---------------------------------------------------------------------------
// tb_flt2fix_unit
//   Self-checking bench for flt2fix_unit. Expected {ovf, fix_out} and latency
//   come from an arithmetic reference model and are queued when a start is
//   driven, then popped when done is observed.
// ---------------------------------------------------------------------------
module tb_flt2fix_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] fp_in;
  logic [15:0] fix_out;
  logic        ovf;
  logic        busy;
  logic        done;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          t_acc   = 0;
  logic [15:0] last_exp = 16'h0000;

  logic [16:0] exp_q[$];
  int          lat_q[$];

  flt2fix_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .fp_in   (fp_in),
    .fix_out (fix_out),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Check helper
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: value * 256 computed with wide integers, then
  // saturated to the signed 16-bit range.
  // -------------------------------------------------------------------------
  function automatic logic [16:0] model(input logic [15:0] f);
    int     e;
    longint m;
    longint v;
    logic [15:0] r;
    e = int'(f[14:10]);
    m = longint'({1'b1, f[9:0]});
    if (e == 31 && f[9:0] != 10'd0) return {1'b1, 16'h0000};
    if (e == 0)       v = 0;
    else if (e >= 17) v = m << (e - 17);
    else              v = m >> (17 - e);
    if (!f[15]) begin
      if (v > 32767) return {1'b1, 16'h7FFF};
      r = v[15:0];
      return {1'b0, r};
    end
    if (v > 32768)  return {1'b1, 16'h8000};
    if (v == 32768) return {1'b0, 16'h8000};
    r = 16'(-v);
    return {1'b0, r};
  endfunction

  function automatic int model_lat(input logic [15:0] f);
    int e;
    e = int'(f[14:10]);
    if (e >= 7 && e <= 16) return 2 + (17 - e);
    if (e >= 17 && e <= 21) return 2 + (e - 17);
    return 2;
  endfunction

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic start_op(input logic [15:0] f);
    @(negedge clk);
    start = 1'b1;
    fp_in = f;
    exp_q.push_back(model(f));
    lat_q.push_back(model_lat(f));
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
  endtask

  task automatic wait_done();
    logic [16:0] e;
    int          el;
    bit          got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!got) begin
      chk("timeout", 0, 1);
    end else begin
      chk("fix_out", fix_out, e[15:0]);
      chk("ovf", ovf, e[16]);
      chk("latency", cyc - t_acc, el);
      chk("busy_at_done", busy, 0);
    end
    last_exp = e[15:0];
  endtask

  task automatic run_one(input logic [15:0] f);
    start_op(f);
    wait_done();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [15:0] directed [12] = '{
    16'h3C00, 16'hC000, 16'h3800, 16'h1C00, 16'h57F0, 16'h5800,
    16'hD800, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8000
  };

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fp_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_fix", fix_out, 16'h0000);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Directed operands, run back to back (each start lands in DONE)
    foreach (directed[i]) run_one(directed[i]);

    // Spot checks on known constants, independent of the model
    run_one(16'h3C00);
    chk("const_p1", fix_out, 16'h0100);
    run_one(16'h1C00);
    chk("const_2m8", fix_out, 16'h0001);
    run_one(16'hD800);
    chk("const_m128", {ovf, fix_out}, {1'b0, 16'h8000});

    // start during SHIFT is ignored; fix_out holds the previous result
    start_op(16'h1C00);
    repeat (3) @(negedge clk);
    chk("hold_shift", fix_out, last_exp);
    start = 1'b1;
    fp_in = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    chk("hold_busy", busy, 1);
    wait_done();

    // Get a nonzero result, then reset in the middle of SHIFT
    run_one(16'h57F0);
    start_op(16'h1C00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_fix", fix_out, 16'h0000);
    chk("arst_ovf", ovf, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge clk);
    // Release reset and request on the very next edge
    reset = 1'b0;
    start = 1'b1;
    fp_in = 16'h3C00;
    exp_q.push_back(model(16'h3C00));
    lat_q.push_back(model_lat(16'h3C00));
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
    chk("post_rst_busy", busy, 1);
    wait_done();
    chk("post_rst_val", fix_out, 16'h0100);

    // Random operands across all exponents
    for (int i = 0; i < 40; i++) begin
      logic [15:0] f;
      f[15]    = 1'($urandom_range(0, 1));
      f[14:10] = 5'($urandom_range(0, 31));
      f[9:0]   = 10'($urandom_range(0, 1023));
      run_one(f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flt2fix_unit.md
FLT2FIX_UNIT -- requirements
Module: flt2fix_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled on the rising clk edge.
REQ-005 fp_in  input  16  IEEE half-precision operand {sign, exp[4:0], man[9:0]}; sampled only when start is accepted.
REQ-006 fix_out  output  16  signed two's-complement 8.8 fixed-point result {int[7:0], frac[7:0]}.
REQ-007 ovf  output  1  result saturated, or operand was NaN; valid while done=1.
REQ-008 busy  output  1  conversion in progress.
REQ-009 done  output  1  level; result valid; held until the next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, CLASSIFY, SHIFT, FINISH, DONE.
REQ-011 SHALL accept start only in IDLE or DONE: latch fp_in, clear done and ovf, go to CLASSIFY, and raise busy.
REQ-012 SHALL ignore start while busy=1; the operand latched earlier is unaffected.
REQ-013 CLASSIFY (1 cycle) SHALL set mag = {1'b1, man} as a 16-bit value and shift count k as follows:
- exp=0 (zero or subnormal): result 0, k=0.
- exp<=6: result 0, k=0 (value below 2^-8).
- 7<=exp<=16: right shift, k = 17-exp.
- 17<=exp<=21: left shift, k = exp-17.
- exp>=22, including inf: overflow, k=0.
- exp=31 with man!=0: NaN, k=0.
REQ-014 SHIFT SHALL move mag by exactly one bit per cycle in the chosen direction and decrement k; SHIFT is skipped entirely when k=0.
REQ-015 Right shifts SHALL truncate, discarding shifted-out bits, so rounding is toward zero on the magnitude.
REQ-016 FINISH (1 cycle) SHALL register fix_out, then enter DONE with done=1 and busy=0. fix_out values:
- sign=1: fix_out = -mag.
- sign=0: fix_out = mag.
- Overflow, sign=0: fix_out = 16'h7FFF, ovf=1.
- Overflow, sign=1, exp=22, man=0 (exactly -128.0): fix_out = 16'h8000, ovf=0.
- Overflow, sign=1, any other case: fix_out = 16'h8000, ovf=1.
- NaN: fix_out = 16'h0000, ovf=1.
- Zero or underflow result: fix_out = 16'h0000 for either sign (no negative zero), ovf=0.
REQ-017 Latency SHALL be 2+k edges: start accepted at edge N, done=1 after edge N+2+k; maximum 12 (exp=7).
REQ-018 fix_out SHALL change only in FINISH; it holds its previous value during CLASSIFY and SHIFT.
REQ-019 start in DONE SHALL begin a new conversion in the same edge that drops done (back-to-back operation, no IDLE cycle required).
REQ-020 Intermediate magnitude SHALL be 16-bit unsigned; the left-shift range (k<=4) guarantees no bit loss before FINISH.

Reset
REQ-021 While reset=1, state=IDLE and outputs SHALL be: fix_out=16'h0000, ovf=0, busy=0, done=0. Internal operand, mag and k are cleared.
REQ-022 Reset asserted mid-conversion SHALL abort immediately, asynchronously, with no partial result visible on fix_out.
REQ-023 After reset deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-024 fp_in=16'h3C00 (+1.0) -> fix_out=16'h0100, ovf=0, done 4 edges after start.
REQ-025 fp_in=16'hC000 (-2.0) -> fix_out=16'hFE00; fp_in=16'h3800 (+0.5) -> 16'h0080; fp_in=16'h1C00 (2^-8) -> 16'h0001 at latency 12.
REQ-026 fp_in=16'h57F0 (+127.0) -> fix_out=16'h7F00, ovf=0, latency 6; fp_in=16'h5800 (+128.0) -> 16'h7FFF, ovf=1; fp_in=16'hD800 (-128.0) -> 16'h8000, ovf=0.
REQ-027 Special operands:
- 16'h7C00 -> 16'h7FFF, ovf=1.
- 16'hFC00 -> 16'h8000, ovf=1.
- 16'h7E00 -> 16'h0000, ovf=1.
- 16'h0001 and 16'h8000 -> 16'h0000, ovf=0, latency 2.
REQ-028 Start pulsed again during SHIFT with a different fp_in -> ignored; first result correct. Start in DONE -> done drops next edge and the new result appears after 2+k edges.
REQ-029 Reset asserted during SHIFT of 16'h1C00 -> outputs zero immediately. The next start with 16'h3C00 yields 16'h0100.
